tex_mem_sched: RTL and testbench
================================

# tex_mem_sched

Texture memory request scheduler: sits directly upstream of the texture cache request port. It accepts one texture fetch per handshake, carrying NUM_TEXELS word addresses per active lane (e.g. 4 for bilinear). It issues them to the texture cache as NUM_TEXELS request beats, tracks per-lane acceptance, and gathers the read responses. It returns one combined response to the texture unit once every expected texel word has arrived.

## Interface
Parameters:
- NUM_REQS, 4, lanes; equals the texture cache request port count
- NUM_TEXELS, 4, texel addresses per lane per fetch (power of two, ≥2)
- WORD_SIZE, 4, bytes per cache word
- ADDR_WIDTH, 30, word address width
- REQ_TAG_WIDTH, 8, upstream fetch tag width
- Derived: TAG_WIDTH = $clog2(NUM_TEXELS); CNT_WIDTH = $clog2(NUM_REQS*NUM_TEXELS+1)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  fetch request valid
- req_tmask  in  NUM_REQS  active lanes
- req_addr  in  NUM_REQS×NUM_TEXELS×ADDR_WIDTH  texel word addresses
- req_tag  in  REQ_TAG_WIDTH  fetch tag
- req_ready  out  1  fetch accepted
- tcache_req_valid  out  NUM_REQS  per-lane cache request valid
- tcache_req_rw  out  NUM_REQS  always 0 (read)
- tcache_req_byteen  out  NUM_REQS×WORD_SIZE  always all ones
- tcache_req_addr  out  NUM_REQS×ADDR_WIDTH  word address
- tcache_req_data  out  NUM_REQS×8·WORD_SIZE  always 0
- tcache_req_tag  out  NUM_REQS×TAG_WIDTH  texel index
- tcache_req_ready  in  NUM_REQS  per-lane accept
- tcache_rsp_valid  in  NUM_REQS  per-lane response valid
- tcache_rsp_data  in  NUM_REQS×8·WORD_SIZE  read data
- tcache_rsp_tag  in  NUM_REQS×TAG_WIDTH  texel index echoed
- tcache_rsp_ready  out  1  response accept
- rsp_valid  out  1  gathered fetch valid
- rsp_tmask  out  NUM_REQS  latched tmask
- rsp_data  out  NUM_REQS×NUM_TEXELS×8·WORD_SIZE  gathered texels
- rsp_tag  out  REQ_TAG_WIDTH  latched req_tag
- rsp_ready  in  1  downstream accept

## Operation
- One fetch in flight at a time. The FSM has states IDLE, SEND, WAIT, RSP.
- IDLE: req_ready=1. When req_valid is high:
  - latch tmask, addresses and tag; clear the data buffer; set texel_idx=0, pending=tmask, rsp_cnt=0.
  - Go to SEND, or to RSP if tmask==0 (returns zero data).
- SEND: tcache_req_valid=pending. Each lane drives addr[lane][texel_idx] with tag=texel_idx.
  - A lane with valid&ready clears its pending bit that cycle. Lanes issue independently; partial acceptance is legal.
  - When pending is zero after the clears and texel_idx<NUM_TEXELS-1: increment texel_idx and reload pending=tmask (the next beat is driven the following cycle).
  - When pending is zero after the clears and texel_idx==NUM_TEXELS-1: go to WAIT.
- Responses: tcache_rsp_ready=1 in every state.
  - In SEND/WAIT, each valid lane writes rsp_data[lane][rsp_tag[lane]], and rsp_cnt increases by popcount(tcache_rsp_valid).
  - In IDLE/RSP, responses are dropped.
  - Expected total = popcount(tmask)·NUM_TEXELS.
- WAIT: when rsp_cnt (including this cycle's arrivals) equals the expected total, go to RSP.
- RSP: rsp_valid=1 with the latched tmask, tag and data. On rsp_ready, go to IDLE.
- Responses in SEND that complete the count are accumulated. The RSP transition still happens only via WAIT, so the earliest is the cycle after WAIT is entered.

## Timing
- Reset values (reset_n low at a clk edge):
  - state=IDLE; every valid output 0; rsp_data/rsp_tmask/rsp_tag 0; counters 0.
  - Reset mid-fetch abandons the fetch. Late responses are dropped in IDLE.
- Combinational outputs:
  - req_ready depends only on state (no req_valid path).
  - tcache_req_valid comes from registered pending only; there is no comb path from tcache_req_ready.
- Latency with all ready high: request accepted cycle 0 → beat i driven in cycle 1+i → WAIT in cycle 1+NUM_TEXELS → rsp_valid the cycle after the final response is counted.
- rsp_valid is held, with data stable, until rsp_ready. The next req_ready is high the cycle after the RSP handshake.
- Simultaneous responses on all lanes in one cycle are all counted. rsp_cnt never exceeds NUM_REQS·NUM_TEXELS.

## Test plan
- Full mask, NUM_REQS=4, NUM_TEXELS=4, ready always high, 2-cycle cache echo:
  - required: beats in cycles 1–4 with tags 0..3, all 16 words gathered in their lane/texel slots, rsp_valid once, rsp_tag equal to req_tag.
- tmask=4'b0101, lane 2 ready low for 3 cycles on beat 0:
  - required: lane 0 fires beat 0 once and is not re-requested, beat 1 is not driven until lane 2 accepts, 8 responses are expected, completion occurs at 8.
- tmask=0, tag=8'h5A:
  - required: rsp_valid in cycle 1 with zero data and tag 8'h5A; no tcache requests.
- Responses returned out of order (tags 3,1,0,2) with lanes interleaved:
  - required: each word lands at [lane][tag]; rsp_valid only after the last one.
- rsp_ready held low for 5 cycles:
  - required: rsp outputs stable, req_ready=0 throughout, new fetch accepted after the handshake.
- reset_n pulsed low during SEND, then 3 stale responses:
  - required: all valids 0 after reset, stale responses dropped, the next fetch gathers correct data.

Source files
------------

// File: rtl/tex_mem_sched.sv
// -----------------------------------------------------------------------------
// tex_mem_sched
//
// Texture memory request scheduler placed in front of the texture cache
// request port. One texture fetch is in flight at a time. Each fetch carries
// NUM_TEXELS word addresses per active lane. The fetch is issued to the cache
// as NUM_TEXELS request beats, with the texel index as the cache tag. Read
// responses are gathered into a per-lane/per-texel buffer. One combined
// response is returned when every expected word has arrived.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   req_*                 fetch request from the texture unit (valid/ready)
//   tcache_req_*          per-lane read requests to the texture cache
//   tcache_rsp_*          per-lane read responses from the texture cache
//   rsp_*                 gathered fetch response to the texture unit
//
// Flat vector layout: element [lane][texel] of req_addr / rsp_data occupies
// slot (lane*NUM_TEXELS + texel). Per-lane cache buses use slot lane.
// -----------------------------------------------------------------------------
module tex_mem_sched #(
    parameter int NUM_REQS      = 4,
    parameter int NUM_TEXELS    = 4,
    parameter int WORD_SIZE     = 4,
    parameter int ADDR_WIDTH    = 30,
    parameter int REQ_TAG_WIDTH = 8,
    parameter int TAG_WIDTH     = $clog2(NUM_TEXELS),
    parameter int CNT_WIDTH     = $clog2(NUM_REQS*NUM_TEXELS+1),
    parameter int DATA_WIDTH    = 8*WORD_SIZE
) (
    input  logic                                          clk,
    input  logic                                          reset_n,

    input  logic                                          req_valid,
    input  logic [NUM_REQS-1:0]                           req_tmask,
    input  logic [NUM_REQS*NUM_TEXELS*ADDR_WIDTH-1:0]     req_addr,
    input  logic [REQ_TAG_WIDTH-1:0]                      req_tag,
    output logic                                          req_ready,

    output logic [NUM_REQS-1:0]                           tcache_req_valid,
    output logic [NUM_REQS-1:0]                           tcache_req_rw,
    output logic [NUM_REQS*WORD_SIZE-1:0]                 tcache_req_byteen,
    output logic [NUM_REQS*ADDR_WIDTH-1:0]                tcache_req_addr,
    output logic [NUM_REQS*DATA_WIDTH-1:0]                tcache_req_data,
    output logic [NUM_REQS*TAG_WIDTH-1:0]                 tcache_req_tag,
    input  logic [NUM_REQS-1:0]                           tcache_req_ready,

    input  logic [NUM_REQS-1:0]                           tcache_rsp_valid,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]                tcache_rsp_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]                 tcache_rsp_tag,
    output logic                                          tcache_rsp_ready,

    output logic                                          rsp_valid,
    output logic [NUM_REQS-1:0]                           rsp_tmask,
    output logic [NUM_REQS*NUM_TEXELS*DATA_WIDTH-1:0]     rsp_data,
    output logic [REQ_TAG_WIDTH-1:0]                      rsp_tag,
    input  logic                                          rsp_ready
);

    localparam logic [TAG_WIDTH-1:0] LAST_IDX = TAG_WIDTH'(NUM_TEXELS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(NUM_REQS * NUM_TEXELS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } state_t;

    typedef logic [NUM_REQS-1:0][NUM_TEXELS-1:0][ADDR_WIDTH-1:0] addr_buf_t;
    typedef logic [NUM_REQS-1:0][NUM_TEXELS-1:0][DATA_WIDTH-1:0] data_buf_t;

    state_t                     state_q, state_d;
    logic [NUM_REQS-1:0]        tmask_q, tmask_d;
    addr_buf_t                  addr_q, addr_d;
    logic [REQ_TAG_WIDTH-1:0]   tag_q, tag_d;
    data_buf_t                  data_q, data_d;
    logic [TAG_WIDTH-1:0]       texel_idx_q, texel_idx_d;
    logic [NUM_REQS-1:0]        pending_q, pending_d;
    logic [CNT_WIDTH-1:0]       rsp_cnt_q, rsp_cnt_d;

    logic [CNT_WIDTH-1:0]       arr_cnt;      // responses arriving this cycle
    logic [CNT_WIDTH:0]         cnt_sum;      // one extra bit so overflow is visible
    logic [CNT_WIDTH-1:0]       cnt_next;     // saturated running count
    logic [CNT_WIDTH-1:0]       exp_total;    // popcount(tmask) * NUM_TEXELS
    logic [NUM_REQS-1:0]        pending_left; // lanes still owing the current beat
    logic                       collect;      // responses are gathered only while a fetch is live

    // ------------------------------------------------------------------
    // Response counting
    // ------------------------------------------------------------------
    always_comb begin
        arr_cnt = '0;
        for (int l = 0; l < NUM_REQS; l++) begin
            arr_cnt = arr_cnt + CNT_WIDTH'(tcache_rsp_valid[l]);
        end
    end

    always_comb begin
        exp_total = '0;
        for (int l = 0; l < NUM_REQS; l++) begin
            if (tmask_q[l]) begin
                exp_total = exp_total + CNT_WIDTH'(NUM_TEXELS);
            end
        end
    end

    // Saturate so a misbehaving cache cannot wrap the counter back past
    // the completion value.
    assign cnt_sum  = {1'b0, rsp_cnt_q} + {1'b0, arr_cnt};
    assign cnt_next = (cnt_sum > {1'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_WIDTH-1:0];

    assign pending_left = pending_q & ~tcache_req_ready;
    assign collect      = (state_q == SEND) || (state_q == WAIT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        tmask_d     = tmask_q;
        addr_d      = addr_q;
        tag_d       = tag_q;
        data_d      = data_q;
        texel_idx_d = texel_idx_q;
        pending_d   = pending_q;
        rsp_cnt_d   = rsp_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tmask_d     = req_tmask;
                    addr_d      = req_addr;
                    tag_d       = req_tag;
                    data_d      = '0;
                    texel_idx_d = '0;
                    pending_d   = req_tmask;
                    rsp_cnt_d   = '0;
                    // An empty mask has nothing to fetch: answer with zeros.
                    state_d     = (req_tmask == '0) ? RSP : SEND;
                end
            end

            SEND: begin
                if (pending_left == '0) begin
                    if (texel_idx_q == LAST_IDX) begin
                        pending_d = '0;
                        state_d   = WAIT;
                    end else begin
                        texel_idx_d = texel_idx_q + 1'b1;
                        pending_d   = tmask_q;
                    end
                end else begin
                    // Lanes that were accepted drop out; the rest retry.
                    pending_d = pending_left;
                end
            end

            WAIT: begin
                if (cnt_next == exp_total) begin
                    state_d = RSP;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Gather responses. The echoed cache tag is the texel index, so
        // each word lands in its own [lane][texel] slot regardless of order.
        if (collect) begin
            for (int l = 0; l < NUM_REQS; l++) begin
                if (tcache_rsp_valid[l]) begin
                    data_d[l][tcache_rsp_tag[l*TAG_WIDTH +: TAG_WIDTH]] =
                        tcache_rsp_data[l*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            rsp_cnt_d = cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tmask_q     <= '0;
            addr_q      <= '0;
            tag_q       <= '0;
            data_q      <= '0;
            texel_idx_q <= '0;
            pending_q   <= '0;
            rsp_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tmask_q     <= tmask_d;
            addr_q      <= addr_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            texel_idx_q <= texel_idx_d;
            pending_q   <= pending_d;
            rsp_cnt_q   <= rsp_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready        = (state_q == IDLE);
    assign rsp_valid        = (state_q == RSP);
    assign tcache_rsp_ready = 1'b1;

    // Driven purely from registered state; no path from tcache_req_ready.
    assign tcache_req_valid = (state_q == SEND) ? pending_q : '0;

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_lane
            assign tcache_req_rw[gi]                               = 1'b0;
            assign tcache_req_byteen[gi*WORD_SIZE +: WORD_SIZE]    = '1;
            assign tcache_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]    = addr_q[gi][texel_idx_q];
            assign tcache_req_data[gi*DATA_WIDTH +: DATA_WIDTH]    = '0;
            assign tcache_req_tag[gi*TAG_WIDTH +: TAG_WIDTH]       = texel_idx_q;
        end
    endgenerate

    assign rsp_tmask = tmask_q;
    assign rsp_tag   = tag_q;
    assign rsp_data  = data_q;

endmodule

// File: tb/tb_tex_mem_sched.sv
// -----------------------------------------------------------------------------
// tb_tex_mem_sched
//
// Scoreboard bench for tex_mem_sched. The stimulus side computes the expected
// gathered response from the fetch addresses and a fixed memory function and
// queues it; a monitor pops and compares on every rsp handshake. A behavioural
// cache model accepts requests, returns the memory word after a delay and can
// reorder responses per lane.
// -----------------------------------------------------------------------------
module tb_tex_mem_sched;

    localparam int NR  = 4;
    localparam int NT  = 4;
    localparam int WS  = 4;
    localparam int AW  = 30;
    localparam int RTW = 8;
    localparam int TW  = 2;
    localparam int DW  = 32;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   req_valid;
    logic [NR-1:0]          req_tmask;
    logic [NR*NT*AW-1:0]    req_addr;
    logic [RTW-1:0]         req_tag;
    logic                   req_ready;
    logic [NR-1:0]          tcache_req_valid;
    logic [NR-1:0]          tcache_req_rw;
    logic [NR*WS-1:0]       tcache_req_byteen;
    logic [NR*AW-1:0]       tcache_req_addr;
    logic [NR*DW-1:0]       tcache_req_data;
    logic [NR*TW-1:0]       tcache_req_tag;
    logic [NR-1:0]          tcache_req_ready;
    logic [NR-1:0]          tcache_rsp_valid;
    logic [NR*DW-1:0]       tcache_rsp_data;
    logic [NR*TW-1:0]       tcache_rsp_tag;
    logic                   tcache_rsp_ready;
    logic                   rsp_valid;
    logic [NR-1:0]          rsp_tmask;
    logic [NR*NT*DW-1:0]    rsp_data;
    logic [RTW-1:0]         rsp_tag;
    logic                   rsp_ready;

    always #5 clk = ~clk;

    tex_mem_sched #(
        .NUM_REQS      (NR),
        .NUM_TEXELS    (NT),
        .WORD_SIZE     (WS),
        .ADDR_WIDTH    (AW),
        .REQ_TAG_WIDTH (RTW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_tmask         (req_tmask),
        .req_addr          (req_addr),
        .req_tag           (req_tag),
        .req_ready         (req_ready),
        .tcache_req_valid  (tcache_req_valid),
        .tcache_req_rw     (tcache_req_rw),
        .tcache_req_byteen (tcache_req_byteen),
        .tcache_req_addr   (tcache_req_addr),
        .tcache_req_data   (tcache_req_data),
        .tcache_req_tag    (tcache_req_tag),
        .tcache_req_ready  (tcache_req_ready),
        .tcache_rsp_valid  (tcache_rsp_valid),
        .tcache_rsp_data   (tcache_rsp_data),
        .tcache_rsp_tag    (tcache_rsp_tag),
        .tcache_rsp_ready  (tcache_rsp_ready),
        .rsp_valid         (rsp_valid),
        .rsp_tmask         (rsp_tmask),
        .rsp_data          (rsp_data),
        .rsp_tag           (rsp_tag),
        .rsp_ready         (rsp_ready)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Contents of the texture memory as seen by the cache model.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] t;
        t = {2'b00, a} * 32'h9E3779B1;
        return t ^ 32'h5BD1E995;
    endfunction

    typedef struct {
        logic [NR-1:0]       tmask;
        logic [RTW-1:0]      tag;
        logic [NR*NT*DW-1:0] data;
        int                  words;
    } exp_t;

    exp_t exp_q[$];
    logic [AW-1:0] cur_addr [NR][NT];

    // Reference: active lanes receive the memory word of every texel address,
    // inactive lanes read as zero; one word is expected per active texel.
    function automatic exp_t model(input logic [NR-1:0] m, input logic [RTW-1:0] tg);
        exp_t e;
        e.tmask = m;
        e.tag   = tg;
        e.data  = '0;
        e.words = 0;
        for (int l = 0; l < NR; l++) begin
            for (int t = 0; t < NT; t++) begin
                if (m[l]) begin
                    e.data[(l*NT+t)*DW +: DW] = mem_word(cur_addr[l][t]);
                    e.words++;
                end
            end
        end
        return e;
    endfunction

    task automatic rand_addrs();
        for (int l = 0; l < NR; l++)
            for (int t = 0; t < NT; t++)
                cur_addr[l][t] = AW'($urandom());
    endtask

    // ------------------------------------------------------------ cache model
    typedef struct {
        int            lane;
        logic [TW-1:0] tag;
        logic [AW-1:0] addr;
        int            due;
    } cent_t;

    typedef struct {
        int cyc;
        int lane;
        int tag;
    } fire_t;

    cent_t          cq[$];
    fire_t          fire_log[$];
    int             echo_min   = 2;
    int             echo_max   = 2;
    bit             rand_ready = 1'b0;
    bit             rand_rsp   = 1'b0;
    logic [NR-1:0]  force_mask = '0;
    int             force_cnt  = 0;
    int             delivered  = 0;
    int             accept_cyc = 0;

    initial begin
        cent_t c;
        fire_t f;
        int    cand[$];
        int    pick;
        tcache_req_ready = '1;
        tcache_rsp_valid = '0;
        tcache_rsp_data  = '0;
        tcache_rsp_tag   = '0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (rsp_valid) check("no_req_during_rsp", tcache_req_valid, 0);
                for (int l = 0; l < NR; l++) begin
                    if (tcache_req_valid[l] && tcache_req_ready[l]) begin
                        c.lane = l;
                        c.tag  = tcache_req_tag[l*TW +: TW];
                        c.addr = tcache_req_addr[l*AW +: AW];
                        c.due  = cyc + $urandom_range(echo_max, echo_min);
                        cq.push_back(c);
                        f.cyc  = cyc;
                        f.lane = l;
                        f.tag  = int'(c.tag);
                        fire_log.push_back(f);
                    end
                end
            end
            @(posedge clk);
            #2;
            for (int l = 0; l < NR; l++) begin
                if (force_cnt > 0 && force_mask[l]) tcache_req_ready[l] = 1'b0;
                else if (rand_ready)                tcache_req_ready[l] = ($urandom_range(0, 3) != 0);
                else                                tcache_req_ready[l] = 1'b1;
            end
            if (force_cnt > 0) force_cnt--;
            tcache_rsp_valid = '0;
            for (int l = 0; l < NR; l++) begin
                cand.delete();
                for (int i = 0; i < cq.size(); i++)
                    if (cq[i].lane == l && cq[i].due <= cyc) cand.push_back(i);
                if (cand.size() > 0 && (!rand_rsp || $urandom_range(0, 1) == 1)) begin
                    pick = rand_rsp ? cand[$urandom_range(0, cand.size()-1)] : cand[0];
                    tcache_rsp_valid[l]          = 1'b1;
                    tcache_rsp_data[l*DW +: DW]  = mem_word(cq[pick].addr);
                    tcache_rsp_tag[l*TW +: TW]   = cq[pick].tag;
                    cq.delete(pick);
                    delivered++;
                end
            end
        end
    end

    // ------------------------------------------------------- rsp_ready driver
    int rsp_hold       = 0;
    bit rand_rsp_ready = 1'b0;

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rsp_hold > 0) begin
                rsp_ready = 1'b0;
                if (rsp_valid) rsp_hold--;
            end else begin
                rsp_ready = rand_rsp_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- monitor
    initial begin
        exp_t                e;
        logic [NR-1:0]       s_tmask;
        logic [RTW-1:0]      s_tag;
        logic [NR*NT*DW-1:0] s_data;
        bit                  stalled;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n || !rsp_valid) begin
                stalled = 1'b0;
            end else begin
                check("req_ready_low_in_rsp", req_ready, 0);
                if (stalled) begin
                    check("hold_tmask", rsp_tmask, s_tmask);
                    check("hold_tag",   rsp_tag,   s_tag);
                    check("hold_data",  rsp_data,  s_data);
                end else if (exp_q.size() > 0) begin
                    check("words_before_rsp", delivered, exp_q[0].words);
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL rsp_unexpected: got tag %0h required no response", rsp_tag);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_tmask", rsp_tmask, e.tmask);
                        check("rsp_tag",   rsp_tag,   e.tag);
                        check("rsp_data",  rsp_data,  e.data);
                        check("const_outputs",
                              {tcache_rsp_ready, tcache_req_rw, tcache_req_byteen, tcache_req_data},
                              {1'b1, {NR{1'b0}}, {NR*WS{1'b1}}, {NR*DW{1'b0}}});
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    s_tmask = rsp_tmask;
                    s_tag   = rsp_tag;
                    s_data  = rsp_data;
                end
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic send_fetch(input logic [NR-1:0] m, input logic [RTW-1:0] tg);
        exp_t e;
        int   waited;
        bit   ok;
        e      = model(m, tg);
        waited = 0;
        ok     = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_tmask = m;
        req_tag   = tg;
        for (int l = 0; l < NR; l++)
            for (int t = 0; t < NT; t++)
                req_addr[(l*NT+t)*AW +: AW] = cur_addr[l][t];
        while (!ok && waited < 2000) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            else           waited++;
        end
        if (ok) begin
            accept_cyc = cyc;
            delivered  = 0;
            exp_q.push_back(e);
        end else begin
            check("req_accept_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            check("completion_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        tests_run++;
        tests_failed++;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        int bad;
        int n00;
        int t_l2b0;
        int t_b1;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_tmask = '0;
        req_addr  = '0;
        req_tag   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready",  req_ready, 1);
        check("reset_rsp_valid",  rsp_valid, 0);
        check("reset_tc_valid",   tcache_req_valid, 0);
        check("reset_rsp_data",   rsp_data, 0);
        check("reset_rsp_tmask",  rsp_tmask, 0);
        check("reset_rsp_tag",    rsp_tag, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Full mask, all ready, 2-cycle echo: beat i at accept+1+i
        rand_addrs();
        fire_log.delete();
        send_fetch(4'b1111, 8'hC3);
        wait_done();
        bad = 0;
        foreach (fire_log[i])
            if (fire_log[i].cyc != accept_cyc + 1 + fire_log[i].tag) bad++;
        check("t1_beat_timing", bad, 0);
        check("t1_fire_count", fire_log.size(), 16);

        // tmask 0101 with lane 2 refusing beat 0 for three cycles
        rand_addrs();
        fire_log.delete();
        force_mask = 4'b0100;
        force_cnt  = 4;
        send_fetch(4'b0101, 8'h21);
        wait_done();
        n00    = 0;
        t_l2b0 = -1;
        t_b1   = 1 << 30;
        foreach (fire_log[i]) begin
            if (fire_log[i].lane == 0 && fire_log[i].tag == 0) n00++;
            if (fire_log[i].lane == 2 && fire_log[i].tag == 0) t_l2b0 = fire_log[i].cyc;
            if (fire_log[i].tag == 1 && fire_log[i].cyc < t_b1) t_b1 = fire_log[i].cyc;
        end
        check("t2_lane0_beat0_once", n00, 1);
        check("t2_lane2_beat0_cycle", t_l2b0, accept_cyc + 4);
        check("t2_beat1_after_lane2", (t_b1 > t_l2b0), 1);
        check("t2_fire_count", fire_log.size(), 8);

        // Empty mask: immediate zero response, no cache traffic
        rand_addrs();
        fire_log.delete();
        send_fetch(4'b0000, 8'h5A);
        @(negedge clk);
        check("t3_rsp_cycle1", rsp_valid, 1);
        wait_done();
        check("t3_no_cache_req", fire_log.size(), 0);

        // Out-of-order responses with lanes interleaved
        rand_addrs();
        echo_min = 6;
        echo_max = 6;
        rand_rsp = 1'b1;
        send_fetch(4'b1111, 8'h3C);
        wait_done();
        rand_rsp = 1'b0;
        echo_min = 2;
        echo_max = 2;

        // Downstream stall for 5 cycles, then back-to-back fetch
        rand_addrs();
        rsp_hold = 5;
        send_fetch(4'b1110, 8'h77);
        rand_addrs();
        send_fetch(4'b0011, 8'h78);
        wait_done();

        // Reset during SEND, stale responses dropped afterwards
        rand_addrs();
        echo_min = 8;
        echo_max = 8;
        send_fetch(4'b1011, 8'h99);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_tc_valid",  tcache_req_valid, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_req_ready", req_ready, 1);
        check("rst_mid_rsp_tmask", rsp_tmask, 0);
        check("rst_mid_rsp_data",  rsp_data, 0);
        check("rst_stale_pending", (cq.size() > 0), 1);
        wait_done();
        echo_min = 2;
        echo_max = 2;
        rand_addrs();
        send_fetch(4'b1111, 8'hA5);
        wait_done();

        // Randomised traffic
        rand_ready     = 1'b1;
        rand_rsp       = 1'b1;
        rand_rsp_ready = 1'b1;
        echo_min       = 1;
        echo_max       = 6;
        for (int k = 0; k < 40; k++) begin
            rand_addrs();
            send_fetch(4'($urandom_range(0, 15)), 8'($urandom()));
        end
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
